// File: rtl/prime_seq_gen.sv
`timescale 1ns/1ps
// Sequential prime generator: enumerates primes 2..limit by trial division, one divisor per clock,
// and streams them over a valid/ready handshake. Define PRIME_SQRT_BOUND_EN to stop trials at div*div > cand.
module prime_seq_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] prime_out_o,
  output logic             prime_valid_o,
  input  logic             prime_ready_i,
  output logic [WIDTH-1:0] prime_count_o
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    EMIT,
    FIN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   cand_q, cand_d;
  logic [WIDTH:0]   div_q, div_d;

  logic             boundHit;
  logic             candDivides;
  logic             atLimit;
  logic [WIDTH:0]   remainder;

  // Candidate carries one extra bit so limit = 2^WIDTH-1 never wraps back to a small value.
`ifdef PRIME_SQRT_BOUND_EN
  logic [2*WIDTH+1:0] divSquare;
  assign divSquare = {{(WIDTH+1){1'b0}}, div_q} * {{(WIDTH+1){1'b0}}, div_q};
  assign boundHit  = divSquare > {{(WIDTH+1){1'b0}}, cand_q};
`else
  assign boundHit  = div_q > (cand_q >> 1);
`endif

  assign remainder   = cand_q % div_q;
  assign candDivides = (remainder == '0);
  assign atLimit     = (cand_q == {1'b0, lim_q});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lim_q   <= '0;
      count_q <= '0;
      cand_q  <= '0;
      div_q   <= (WIDTH+1)'(2);
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      count_q <= count_d;
      cand_q  <= cand_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    count_d = count_q;
    cand_d  = cand_q;
    div_d   = div_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          count_d = '0;
          if (limit_i > WIDTH'(1)) begin
            lim_d   = limit_i;
            cand_d  = (WIDTH+1)'(2);
            div_d   = (WIDTH+1)'(2);
            state_d = CHECK;
          end else begin
            state_d = FIN;
          end
        end
      end
      CHECK: begin
        if (boundHit) begin
          state_d = EMIT;
        end else if (candDivides) begin
          if (atLimit) begin
            state_d = FIN;
          end else begin
            cand_d = cand_q + 1'b1;
            div_d  = (WIDTH+1)'(2);
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      EMIT: begin
        if (prime_ready_i) begin
          count_d = count_q + 1'b1;
          if (atLimit) begin
            state_d = FIN;
          end else begin
            cand_d  = cand_q + 1'b1;
            div_d   = (WIDTH+1)'(2);
            state_d = CHECK;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // prime_out is gated so it reads zero whenever no prime is being offered.
  always_comb begin
    busy_o        = (state_q != IDLE);
    done_o        = (state_q == FIN);
    prime_valid_o = (state_q == EMIT);
    prime_out_o   = (state_q == EMIT) ? cand_q[WIDTH-1:0] : '0;
    prime_count_o = count_q;
  end

endmodule

// File: tb/tb_prime_seq_gen.sv
`timescale 1ns/1ps
// Self-checking bench for prime_seq_gen: a list-of-primes model with a per-cycle compare process,
// randomized consumer stalls and limits, reset-mid-run and start-while-busy scenarios.
module tb_prime_seq_gen;

  localparam int W      = 8;
  localparam int BUDGET = 20000;

  logic         clk;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] limit_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] prime_out_o;
  logic         prime_valid_o;
  logic         prime_ready_i;
  logic [W-1:0] prime_count_o;

  int errors = 0;
  int checks = 0;

  int expQ[$];
  int modelCount   = 0;
  bit finalIsLimit = 0;
  bit flushing     = 0;
  bit readyRand    = 0;
  bit readyConst   = 1;

  prime_seq_gen #(.WIDTH(W)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .limit_i       (limit_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .prime_out_o   (prime_out_o),
    .prime_valid_o (prime_valid_o),
    .prime_ready_i (prime_ready_i),
    .prime_count_o (prime_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit isPrime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_i      = 1'b1;
    flushing   = 1'b1;
    start_i    = 1'b0;
    expQ.delete();
    modelCount = 0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    checkOutput("rstBusy",  {31'b0, busy_o}, 0);
    checkOutput("rstDone",  {31'b0, done_o}, 0);
    checkOutput("rstValid", {31'b0, prime_valid_o}, 0);
    checkOutput("rstOut",   {24'b0, prime_out_o}, 0);
    checkOutput("rstCount", {24'b0, prime_count_o}, 0);
    flushing = 1'b0;
  endtask

  // Consumer: ready either held at a constant or re-rolled every cycle.
  initial begin
    prime_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      prime_ready_i = readyRand ? 1'($urandom % 2) : readyConst;
    end
  end

  // Per-cycle compare against the expected prime list and accepted-count model.
  initial begin
    bit           prevValid;
    bit           prevHs;
    logic [W-1:0] prevOut;
    int           expPrime;
    prevValid = 0;
    prevHs    = 0;
    prevOut   = '0;
    forever begin
      @(negedge clk);
      if (rst_i || flushing) begin
        prevValid = 0;
        prevHs    = 0;
      end else begin
        checkOutput("primeCount", {24'b0, prime_count_o}, modelCount);
        if (prevValid && !prevHs) begin
          checkOutput("validHeld", {31'b0, prime_valid_o}, 1);
          checkOutput("outStable", {24'b0, prime_out_o}, {24'b0, prevOut});
        end
        if (prevHs) checkOutput("gapAfterHs", {31'b0, prime_valid_o}, 0);
        if (prevHs && finalIsLimit && expQ.size() == 0)
          checkOutput("doneAfterLastEmit", {31'b0, done_o}, 1);
        if (prime_valid_o) begin
          checkOutput("busyWhileValid", {31'b0, busy_o}, 1);
          if (prime_ready_i) begin
            if (expQ.size() == 0) begin
              checkOutput("unexpectedPrime", {24'b0, prime_out_o}, 0);
            end else begin
              expPrime = expQ.pop_front();
              checkOutput("primeOut", {24'b0, prime_out_o}, expPrime);
            end
            modelCount++;
          end
        end
        prevValid = prime_valid_o;
        prevHs    = prime_valid_o && prime_ready_i;
        prevOut   = prime_out_o;
      end
    end
  end

  task automatic applyStimulus(input int lim, input bit randReady, input bit glitch, input int glitchLim);
    int expTotal;
    bit seen;
    expQ.delete();
    for (int p = 2; p <= lim; p++) begin
      if (isPrime(p)) expQ.push_back(p);
    end
    expTotal     = expQ.size();
    finalIsLimit = isPrime(lim);
    readyRand    = randReady;
    readyConst   = 1'b1;
    seen         = 0;
    @(posedge clk);
    #1;
    start_i = 1'b1;
    limit_i = lim[W-1:0];
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    limit_i    = W'($urandom);
    modelCount = 0;
    @(negedge clk);
    checkOutput("busyAfterStart", {31'b0, busy_o}, 1);
    if (lim < 2) begin
      checkOutput("doneEarly",  {31'b0, done_o}, 1);
      checkOutput("validNever", {31'b0, prime_valid_o}, 0);
      seen = 1;
    end else begin
      checkOutput("validT1", {31'b0, prime_valid_o}, 0);
      checkOutput("doneT1",  {31'b0, done_o}, 0);
      @(negedge clk);
      checkOutput("validT2",    {31'b0, prime_valid_o}, 1);
      checkOutput("firstPrime", {24'b0, prime_out_o}, 2);
      if (glitch) begin
        @(posedge clk);
        #1;
        start_i = 1'b1;
        limit_i = glitchLim[W-1:0];
        @(posedge clk);
        #1;
        start_i = 1'b0;
      end
      for (int c = 0; c < BUDGET && !seen; c++) begin
        @(negedge clk);
        if (done_o) seen = 1;
      end
    end
    if (!seen) begin
      checkOutput("doneTimeout", 0, 1);
      doReset();
    end else begin
      checkOutput("finalCount", {24'b0, prime_count_o}, expTotal);
      checkOutput("allEmitted", expQ.size(), 0);
      @(negedge clk);
      checkOutput("donePulse", {31'b0, done_o}, 0);
      checkOutput("busyFalls", {31'b0, busy_o}, 0);
    end
  endtask

  task automatic resetMidRun();
    bit sawValid;
    sawValid = 0;
    expQ.delete();
    for (int p = 2; p <= 30; p++) begin
      if (isPrime(p)) expQ.push_back(p);
    end
    finalIsLimit = 0;
    readyRand    = 0;
    readyConst   = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b1;
    limit_i = W'(30);
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    modelCount = 0;
    for (int c = 0; c < 100 && !sawValid; c++) begin
      @(negedge clk);
      if (prime_valid_o) sawValid = 1;
    end
    checkOutput("stallValid", {31'b0, sawValid}, 1);
    doReset();
    readyConst = 1'b1;
  endtask

  initial begin
    int q[$];
    rst_i   = 1'b1;
    start_i = 1'b0;
    limit_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    checkOutput("initBusy",  {31'b0, busy_o}, 0);
    checkOutput("initDone",  {31'b0, done_o}, 0);
    checkOutput("initValid", {31'b0, prime_valid_o}, 0);
    checkOutput("initOut",   {24'b0, prime_out_o}, 0);
    checkOutput("initCount", {24'b0, prime_count_o}, 0);

    // Pin the model against hand-known prime counts.
    for (int p = 2; p <= 255; p++) begin
      if (isPrime(p)) q.push_back(p);
      if (p == 10)  checkOutput("modelPi10", q.size(), 4);
      if (p == 30)  checkOutput("modelPi30", q.size(), 10);
      if (p == 100) checkOutput("modelPi100", q.size(), 25);
    end
    checkOutput("modelPi255", q.size(), 54);
    checkOutput("modelLast255", q[q.size()-1], 251);

    $display("[TB] limit=10, ready high");
    applyStimulus(10, 0, 0, 0);
    $display("[TB] limit=30, random ready");
    applyStimulus(30, 1, 0, 0);
    $display("[TB] limit=0 and limit=1");
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    $display("[TB] limit=255, random ready");
    applyStimulus(255, 1, 0, 0);
    $display("[TB] limit=4 ends on composite");
    applyStimulus(4, 0, 0, 0);
    $display("[TB] reset while stalled, then limit=7");
    resetMidRun();
    applyStimulus(7, 0, 0, 0);
    $display("[TB] limit=100 with start pulsed while busy");
    applyStimulus(100, 1, 1, 50);
    $display("[TB] random limits");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(int'($urandom_range(0, 255)), 1, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prime_seq_gen.md
# prime_seq_gen

Sequential prime generator: on `start`, enumerates every prime p with 2 <= p <= `limit` in ascending order and streams each one out over a valid/ready handshake. It is the producer counterpart to the combinational prime detector. It supplies reference prime sequences to detector benches and to downstream consumers such as table loaders or checkers. Trial division runs one divisor per clock, trading throughput for a small datapath.

## Interface

- `WIDTH`, 16: width of `limit`, `prime_out` and `prime_count`; legal range 4..32.
- `clk`  in  1  rising-edge clock, single domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin enumeration; sampled only in IDLE.
- `limit`  in  WIDTH  inclusive upper bound, latched on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when enumeration finishes.
- `prime_out`  out  WIDTH  current prime; stable while `prime_valid` is high.
- `prime_valid`  out  1  `prime_out` holds a prime.
- `prime_ready`  in  1  consumer accepts `prime_out` when both valid and ready are high.
- `prime_count`  out  WIDTH  number of primes accepted since the last `start`.

## Operation

- FSM states: IDLE, CHECK, EMIT, FIN.
- Internal registers:
  - `lim_q` (WIDTH): latched limit.
  - `cand` (WIDTH+1 bits): candidate; the extra bit makes `limit` = 2^WIDTH-1 safe against wrap-around.
  - `div` (WIDTH+1 bits): current trial divisor.
- IDLE:
  - `start`=1 with `limit` >= 2: latch `lim_q`, set `cand`=2, `div`=2, clear `prime_count`, go to CHECK.
  - `start`=1 with `limit` < 2: clear `prime_count`, go to FIN. No primes are emitted.
- CHECK (one trial per cycle):
  - Bound exceeded (see Configuration): `cand` is prime; go to EMIT.
  - Else if `cand % div` == 0: `cand` is composite. If `cand` == `lim_q`, go to FIN; else `cand`+1, `div`=2, stay in CHECK.
  - Else: `div`+1, stay in CHECK.
- EMIT:
  - `prime_valid`=1 and `prime_out`=`cand[WIDTH-1:0]`, held until handshake.
  - On handshake: `prime_count`+1. If `cand` == `lim_q`, go to FIN; else `cand`+1, `div`=2, go to CHECK.
- FIN: `done`=1 for exactly one cycle, then go to IDLE. `prime_count` holds its final value until the next accepted `start`.
- `start` while `busy`=1 is ignored. `limit` changes after latching have no effect.
- Modulo is a combinational `%` on WIDTH+1 bits. The square-bound product `div*div` is computed at 2*(WIDTH+1) bits; no truncation is allowed.

## Timing

- Reset values: `busy`=0, `done`=0, `prime_valid`=0, `prime_out`=0, `prime_count`=0, FSM=IDLE.
- `rst` has priority over all other inputs. Asserted mid-operation, it returns every output to its reset value on the next edge; an unaccepted prime is dropped.
- With `start` accepted at edge T (`limit` >= 2): first CHECK at T+1, `prime_valid`=1 for prime 2 from T+2.
- `prime_valid` may not drop and `prime_out` may not change until the handshake.
- After the handshake edge, `prime_valid` is 0 for at least one cycle, because at least one CHECK cycle occurs.
- `done` rises exactly one cycle after the final CHECK or EMIT cycle. `busy` falls on the cycle after `done`.
- `limit` < 2: `done` pulses at T+1; `prime_valid` never asserts.
- Per-candidate latency equals (number of divisors tried) + 1 for EMIT; there is no fixed bound.

## Configuration

- Macro: `PRIME_SQRT_BOUND_EN`.
- Defined: bound is exceeded when `div*div > cand`. Trials per candidate are roughly sqrt(cand).
- Undefined: bound is exceeded when `div > cand/2`, with integer division, matching the detector's search range. Trials per candidate are roughly cand/2.
- The emitted prime sequence and `prime_count` are identical in both builds; only latency differs.

## Test plan

- `limit`=10, `prime_ready` tied high → primes 2, 3, 5, 7 in order; `done` pulses once; `prime_count`=4; first `prime_valid` exactly 2 cycles after `start`.
- `limit`=30, `prime_ready` toggled pseudo-randomly → sequence 2,3,5,7,11,13,17,19,23,29 with no drops or duplicates; `prime_out` stable while stalled; `prime_count`=10.
- `limit`=0 and `limit`=1 → no `prime_valid`; `done` pulse one cycle after `start`; `prime_count`=0.
- `WIDTH`=8, `limit`=255 → 54 primes, last 251; no wrap-around of the candidate; `done` asserted. Also check `limit`=4, which ends on composite 4: primes 2, 3, then `done`.
- Assert `rst` while `prime_valid`=1 with `prime_ready`=0 → next cycle all outputs 0, FSM in IDLE; a fresh `start` with `limit`=7 yields 2, 3, 5, 7.
- Pulse `start` again while `busy`=1 with a different `limit` → ignored; original sequence completes. Run both with and without `PRIME_SQRT_BOUND_EN` and compare sequences for `limit`=100; both must yield 25 primes.
